// File: rtl/ms_timer_multi.sv
// ms_timer_multi: parametrised BCD stopwatch/countdown timer. It can count up or down,
// freeze the display for lap times, and expire on a countdown. It drives a multiplexed
// common-anode 7-segment display (segments and digit selects are both active-low).
module ms_timer_multi #(
  parameter int DIGITS   = 4,
  parameter int CLK_DIV  = 50000,
  parameter int SCAN_DIV = 25000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              switch,
  input  logic              inc,
  input  logic              mode,
  input  logic              lap,
  output logic [7:0]        num,
  output logic [DIGITS-1:0] loc,
  output logic              wrap,
  output logic              done
);

  localparam int CW = DIGITS * 4;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_LAP, ST_EXPIRED} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   frozen_q, frozen_d;
  logic            run_mode_q, run_mode_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]   scan_idx_q, scan_idx_d;
  logic            inc_prev_q, inc_prev_d;
  logic            lap_prev_q, lap_prev_d;
  logic [7:0]      num_q, num_d;
  logic [DIGITS-1:0] loc_q, loc_d;
  logic            wrap_q, wrap_d;

  logic inc_edge, lap_edge, running, tick, count_zero, count_one;

  // BCD increment: the carry ripples from the least-significant digit; all-9s wraps to 0.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement: the borrow ripples upward. It is only applied to non-zero counts.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // True when every digit is 9, i.e. the next increment rolls over.
  function automatic logic all_nines(input logic [CW-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*4 +: 4] != 4'd9) r = 1'b0;
    end
    return r;
  endfunction

  assign inc_edge   = inc & ~inc_prev_q;
  assign lap_edge   = lap & ~lap_prev_q;
  assign running    = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick       = running && (presc_q == PRESC_LAST);
  assign count_zero = (count_q == '0);
  assign count_one  = (count_q == CW'(1));

  // State register and all datapath flops, asynchronously cleared to the idle STOP picture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STOP;
      count_q    <= '0;
      frozen_q   <= '0;
      run_mode_q <= 1'b0;
      presc_q    <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      inc_prev_q <= 1'b0;
      lap_prev_q <= 1'b0;
      num_q      <= 8'hC0;
      loc_q      <= ~DIGITS'(1);
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      frozen_q   <= frozen_d;
      run_mode_q <= run_mode_d;
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      inc_prev_q <= inc_prev_d;
      lap_prev_q <= lap_prev_d;
      num_q      <= num_d;
      loc_q      <= loc_d;
      wrap_q     <= wrap_d;
    end
  end

  // Next state and count. In each cycle only the highest-priority event acts: switch, then expiry, then lap, then tick.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    frozen_d   = frozen_q;
    run_mode_d = run_mode_q;
    wrap_d     = 1'b0;
    inc_prev_d = inc;
    lap_prev_d = lap;
    case (state_q)
      ST_STOP: begin
        if (switch) begin
          state_d    = ST_RUN;
          run_mode_d = mode;
        end else if (inc_edge) begin
          count_d = bcd_inc(count_q);
          wrap_d  = all_nines(count_q);
        end
      end
      ST_RUN, ST_LAP: begin
        if (!switch) begin
          state_d = ST_STOP;
        end else if (run_mode_q && count_zero) begin
          state_d = ST_EXPIRED;
        end else if (lap_edge) begin
          if (state_q == ST_RUN) begin
            state_d  = ST_LAP;
            frozen_d = count_q;
          end else begin
            state_d = ST_RUN;
          end
        end else if (tick) begin
          if (run_mode_q) begin
            count_d = bcd_dec(count_q);
            if (count_one) state_d = ST_EXPIRED;
          end else begin
            count_d = bcd_inc(count_q);
            wrap_d  = all_nines(count_q);
          end
        end
      end
      ST_EXPIRED: begin
        if (!switch) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Tick prescaler and scan timer. The prescaler runs only while staying in RUN/LAP and restarts from zero otherwise.
  always_comb begin
    presc_d = '0;
    if (running && (state_d == ST_RUN || state_d == ST_LAP)) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    scan_cnt_d = scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
  end

  // Display output: decode the selected digit of the live count (or of the lap snapshot) into segments and a digit select.
  always_comb begin
    logic [CW-1:0] src;
    logic [3:0]    digit;
    logic          dp_on;
    src   = (state_q == ST_LAP) ? frozen_q : count_q;
    digit = 4'd0;
    dp_on = 1'b0;
    loc_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        digit    = src[i*4 +: 4];
        dp_on    = (DIGITS >= 4) && (i == 3);
        loc_d[i] = 1'b0;
      end
    end
    case (digit)
      4'd0:    num_d = 8'hC0;
      4'd1:    num_d = 8'hF9;
      4'd2:    num_d = 8'hA4;
      4'd3:    num_d = 8'hB0;
      4'd4:    num_d = 8'h99;
      4'd5:    num_d = 8'h92;
      4'd6:    num_d = 8'h82;
      4'd7:    num_d = 8'hF8;
      4'd8:    num_d = 8'h80;
      4'd9:    num_d = 8'h90;
      default: num_d = 8'hFF;
    endcase
    if (dp_on) num_d[7] = 1'b0;
  end

  assign num  = num_q;
  assign loc  = loc_q;
  assign wrap = wrap_q;
  assign done = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_ms_timer_multi.sv
// Testbench for ms_timer_multi (DIGITS=4, CLK_DIV=4, SCAN_DIV=2). It compares the DUT
// every cycle against a decimal-integer reference model, and adds a table of
// post-reset vectors and directed corner-case sequences.
module tb_ms_timer_multi;

  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 4;
  localparam int SCAN_DIV = 2;
  localparam int M_STOP = 0, M_RUN = 1, M_LAP = 2, M_EXP = 3;

  logic clk = 1'b0;
  logic rst, switch, inc, mode, lap;
  logic [7:0] num;
  logic [DIGITS-1:0] loc;
  logic wrap, done;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model state: the count is a plain integer 0..9999.
  int m_state, m_count, m_frozen, m_presc, m_scan_cnt, m_idx;
  bit m_run_mode, m_inc_prev, m_lap_prev, m_wrap;
  logic [7:0] m_num;
  logic [3:0] m_loc;

  typedef struct {
    bit sw; bit i; bit md; bit lp;
    logic [7:0] num; logic [3:0] loc; bit wrap; bit done;
  } vec_t;
  vec_t vecs [12];

  always #5 clk = ~clk;

  ms_timer_multi #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .switch(switch), .inc(inc), .mode(mode), .lap(lap),
    .num(num), .loc(loc), .wrap(wrap), .done(done)
  );

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_STOP; m_count = 0; m_frozen = 0; m_presc = 0;
    m_scan_cnt = 0; m_idx = 0; m_run_mode = 0; m_inc_prev = 0; m_lap_prev = 0;
    m_wrap = 0; m_num = 8'hC0; m_loc = 4'hE;
  endtask

  // Advance the model by one clock edge, starting from its current state and the given inputs.
  task automatic model_step(input bit sw, input bit i, input bit md, input bit lp);
    bit inc_e, lap_e, tick;
    int src, dig, n_state, n_count;
    logic [7:0] s;
    inc_e = i && !m_inc_prev;
    lap_e = lp && !m_lap_prev;
    tick  = (m_state == M_RUN || m_state == M_LAP) && (m_presc == CLK_DIV - 1);
    src = (m_state == M_LAP) ? m_frozen : m_count;
    dig = (src / pow10(m_idx)) % 10;
    s = seg_tab[dig];
    if (m_idx == 3) s[7] = 1'b0;
    m_num = s;
    m_loc = ~(4'b0001 << m_idx);
    if (m_scan_cnt == SCAN_DIV - 1) begin
      m_scan_cnt = 0;
      m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_scan_cnt++;
    end
    n_state = m_state;
    n_count = m_count;
    m_wrap = 0;
    case (m_state)
      M_STOP: begin
        if (sw) begin
          n_state = M_RUN; m_run_mode = md;
        end else if (inc_e) begin
          n_count = (m_count + 1) % 10000;
          m_wrap = (m_count == 9999);
        end
      end
      M_RUN, M_LAP: begin
        if (!sw) n_state = M_STOP;
        else if (m_run_mode && m_count == 0) n_state = M_EXP;
        else if (lap_e) begin
          if (m_state == M_RUN) begin
            n_state = M_LAP; m_frozen = m_count;
          end else begin
            n_state = M_RUN;
          end
        end else if (tick) begin
          if (m_run_mode) begin
            n_count = m_count - 1;
            if (n_count == 0) n_state = M_EXP;
          end else begin
            n_count = (m_count + 1) % 10000;
            m_wrap = (m_count == 9999);
          end
        end
      end
      default: if (!sw) n_state = M_STOP;
    endcase
    if ((m_state == M_RUN || m_state == M_LAP) && (n_state == M_RUN || n_state == M_LAP))
      m_presc = tick ? 0 : m_presc + 1;
    else
      m_presc = 0;
    m_state = n_state;
    m_count = n_count;
    m_inc_prev = i;
    m_lap_prev = lp;
  endtask

  // Drive one cycle of inputs at the falling edge, then compare against the model at the next falling edge.
  task automatic applyStimulus(input bit sw, input bit i, input bit md, input bit lp);
    switch = sw; inc = i; mode = md; lap = lp;
    model_step(sw, i, md, lp);
    @(posedge clk);
    @(negedge clk);
    checkOutput("model_num",  32'(num),  32'(m_num));
    checkOutput("model_loc",  32'(loc),  32'(m_loc));
    checkOutput("model_wrap", 32'(wrap), 32'(m_wrap));
    checkOutput("model_done", 32'(done), 32'(m_state == M_EXP));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; switch = 0; inc = 0; mode = 0; lap = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_num",  32'(num),  32'hC0);
    checkOutput("rst_loc",  32'(loc),  32'hE);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_wrap", 32'(wrap), 32'h0);
    rst = 1'b0;
  endtask

  // Watch one full scan (8 cycles) and rebuild the displayed decimal value; bad segment codes decode as 15.
  task automatic read_display(input bit sw, input bit i, input bit md, input bit lp, output int val);
    int digs [4] = '{15, 15, 15, 15};
    for (int c = 0; c < 8; c++) begin
      applyStimulus(sw, i, md, lp);
      for (int k = 0; k < 4; k++) begin
        if (loc[k] == 1'b0) begin
          digs[k] = 15;
          for (int d = 0; d < 10; d++)
            if ((num | 8'h80) == seg_tab[d]) digs[k] = d;
        end
      end
    end
    val = digs[0] + 10 * digs[1] + 100 * digs[2] + 1000 * digs[3];
  endtask

  initial begin
    int val, wraps, first, cnt;
    bit found;
    bit r_sw;

    // Rows after reset with switch=0: inc edges step the count; loc scans E,E,D,D,B,B,7,7.
    vecs[0]  = '{0, 1, 0, 0, 8'hC0, 4'hE, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 8'hF9, 4'hE, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 8'hC0, 4'hD, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 8'hC0, 4'hD, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 8'hC0, 4'hB, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 8'hC0, 4'hB, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 8'h40, 4'h7, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 8'h40, 4'h7, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 8'hB0, 4'hE, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 8'hB0, 4'hE, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 8'hC0, 4'hD, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 8'hC0, 4'hD, 0, 0};

    rst = 1'b1; switch = 0; inc = 0; mode = 0; lap = 0;
    do_reset();
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].sw, vecs[v].i, vecs[v].md, vecs[v].lp);
      checkOutput($sformatf("vec%0d_num", v),  32'(num),  32'(vecs[v].num));
      checkOutput($sformatf("vec%0d_loc", v),  32'(loc),  32'(vecs[v].loc));
      checkOutput($sformatf("vec%0d_wrap", v), 32'(wrap), 32'(vecs[v].wrap));
      checkOutput($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].done));
    end

    // Run up: the first edge only leaves STOP, so ticks land on edges 5, 9, ..., 41 and the count reaches 10.
    do_reset();
    for (int c = 0; c < 41; c++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    read_display(0, 0, 0, 0, val);
    checkOutput("run_up_count", 32'(val), 32'd10);
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      applyStimulus(0, 0, 0, 0);
      if (loc == 4'hD) begin
        found = 1;
        checkOutput("digit1_seg", 32'(num), 32'hF9);
      end
    end
    checkOutput("digit1_seen", 32'(found), 32'd1);

    // Roll over from 9998: wrap is high for exactly one cycle, after edge 9.
    do_reset();
    for (int n = 0; n < 9998; n++) begin
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end
    read_display(0, 0, 0, 0, val);
    checkOutput("inc_to_9998", 32'(val), 32'd9998);
    wraps = 0; first = -1;
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1, 0, 0, 0);
      if (wrap) begin
        wraps++;
        if (first < 0) first = c;
      end
    end
    checkOutput("wrap_pulses", 32'(wraps), 32'd1);
    checkOutput("wrap_cycle", 32'(first), 32'd9);
    applyStimulus(0, 0, 0, 0);
    read_display(0, 0, 0, 0, val);
    checkOutput("after_wrap", 32'(val), 32'd0);

    // Count down from 3: expires on edge 13 and then holds at zero.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end
    first = -1;
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(1, 0, 1, 0);
      if (done && first < 0) first = c;
    end
    checkOutput("expire_cycle", 32'(first), 32'd13);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, (c % 2) == 0, 1, 0);
      if (done) cnt++;
    end
    checkOutput("done_held", 32'(cnt), 32'd20);
    read_display(1, 0, 1, 0, val);
    checkOutput("expired_count", 32'(val), 32'd0);
    // Asynchronous reset while expired clears done without waiting for a clock edge.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_done", 32'(done), 32'd0);
    checkOutput("async_num",  32'(num),  32'hC0);
    checkOutput("async_loc",  32'(loc),  32'hE);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Entering RUN at zero in down mode expires on the following edge.
    applyStimulus(1, 0, 1, 0);
    checkOutput("zero_down_run", 32'(done), 32'd0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("zero_down_exp", 32'(done), 32'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("exp_to_stop", 32'(done), 32'd0);

    // Lap: snapshot at 5 while counting continues to 10.
    do_reset();
    for (int c = 0; c < 21; c++) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    for (int c = 0; c < 5; c++) applyStimulus(1, 0, 0, 0);
    read_display(1, 0, 0, 0, val);
    checkOutput("lap_frozen", 32'(val), 32'd5);
    for (int c = 0; c < 6; c++) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    read_display(0, 0, 0, 0, val);
    checkOutput("lap_live", 32'(val), 32'd10);

    // inc: a held level counts once; separate pulses count; pulses while running are ignored.
    do_reset();
    for (int c = 0; c < 5; c++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end
    read_display(0, 0, 0, 0, val);
    checkOutput("inc_stop", 32'(val), 32'd4);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    read_display(0, 1, 0, 0, val);
    checkOutput("inc_run_ignored", 32'(val), 32'd4);

    // Reset in the middle of RUN, away from a clock edge.
    do_reset();
    for (int c = 0; c < 10; c++) applyStimulus(1, 0, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrun_num",  32'(num),  32'hC0);
    checkOutput("midrun_loc",  32'(loc),  32'hE);
    checkOutput("midrun_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    read_display(0, 0, 0, 0, val);
    checkOutput("midrun_stays_stop", 32'(val), 32'd0);

    // Random traffic against the model.
    do_reset();
    r_sw = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) r_sw = !r_sw;
      applyStimulus(r_sw, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
